// File: rtl/nes_pad_if.sv
// NES controller port bundle: the host drives latch and pulse, the pad answers on data.
interface nes_pad_if;
    logic nes_latch;
    logic nes_pulse;
    logic nes_data;

    modport master (
        output nes_latch,
        output nes_pulse,
        input  nes_data
    );

    modport slave (
        input  nes_latch,
        input  nes_pulse,
        output nes_data
    );
endinterface

// File: rtl/nes_pad_responder.sv
// Emulates an NES pad's serial shift register on a synchronous clock domain,
// with frame/poll bookkeeping and a link-idle watchdog.
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [23:0] IDLE_TIMEOUT = 24'd1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:7]       buttons_in,
    nes_pad_if.slave         pad,
    output logic             frame_done,
    output logic [3:0]       bit_index,
    output logic [7:0]       poll_count,
    output logic             link_stale
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [SYNC_STAGES-1:0] latch_sync_q, pulse_sync_q;
    logic                   latch_dly_q, pulse_dly_q;
    logic                   latch_s, pulse_s;
    logic                   latch_rise, latch_fall, pulse_rise;

    logic [1:0]  state_q, state_d;
    logic [0:7]  shreg_q, shreg_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic        data_q, data_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  poll_q, poll_d;
    logic [23:0] idle_cnt_q, idle_cnt_d;
    logic [2:0]  nxt_idx;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_dly_q;
    assign latch_fall = ~latch_s & latch_dly_q;
    assign pulse_rise = pulse_s & ~pulse_dly_q;
    assign nxt_idx    = bit_idx_q[2:0] + 3'd1;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        poll_d       = poll_q;

        if (latch_fall) begin
            poll_d = poll_q + 8'd1;
        end

        // A high latch overrides everything, including a coincident pulse edge.
        if (latch_s) begin
            state_d   = StLoad;
            shreg_d   = buttons_in;
            bit_idx_d = 4'd0;
            data_d    = ~buttons_in[0];
        end else begin
            case (state_q)
                StIdle: begin
                    data_d    = 1'b1;
                    bit_idx_d = 4'd0;
                end
                StLoad: begin
                    if (latch_fall) begin
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (pulse_rise) begin
                        if (bit_idx_q == 4'd7) begin
                            bit_idx_d    = 4'd8;
                            data_d       = 1'b0;
                            frame_done_d = 1'b1;
                            state_d      = StDone;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                            data_d    = ~shreg_q[nxt_idx];
                        end
                    end
                end
                default: begin
                    data_d    = 1'b0;
                    bit_idx_d = 4'd8;
                end
            endcase
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (latch_rise) begin
            idle_cnt_d = 24'd0;
        end else if (idle_cnt_q != IDLE_TIMEOUT) begin
            idle_cnt_d = idle_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            latch_dly_q  <= 1'b0;
            pulse_dly_q  <= 1'b0;
            state_q      <= StIdle;
            shreg_q      <= '0;
            bit_idx_q    <= 4'd0;
            data_q       <= 1'b1;
            frame_done_q <= 1'b0;
            poll_q       <= 8'd0;
            idle_cnt_q   <= 24'd0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad.nes_latch};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pad.nes_pulse};
            latch_dly_q  <= latch_s;
            pulse_dly_q  <= pulse_s;
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            poll_q       <= poll_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign pad.nes_data = data_q;
    assign frame_done   = frame_done_q;
    assign bit_index    = bit_idx_q;
    assign poll_count   = poll_q;
    assign link_stale   = (idle_cnt_q == IDLE_TIMEOUT);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: frames, overrun, relatch, collision, timeout, reset.
module tb_nes_pad_responder;

    logic       clk;
    logic       rst;
    logic [0:7] buttons_in;
    logic       frame_done;
    logic [3:0] bit_index;
    logic [7:0] poll_count;
    logic       link_stale;

    int         n_tests;
    int         n_fail;
    int         fd_cnt;
    logic [7:0] exp_poll;
    logic [0:7] frame_exp;

    nes_pad_if bus ();

    nes_pad_responder #(
        .SYNC_STAGES (2),
        .IDLE_TIMEOUT(24'd16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .buttons_in(buttons_in),
        .pad       (bus),
        .frame_done(frame_done),
        .bit_index (bit_index),
        .poll_count(poll_count),
        .link_stale(link_stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic do_latch(input int hi);
        bus.nes_latch = 1'b1;
        repeat (hi) @(negedge clk);
        bus.nes_latch = 1'b0;
        repeat (4) @(negedge clk);
        exp_poll++;
    endtask

    task automatic do_pulse();
        bus.nes_pulse = 1'b1;
        repeat (4) @(negedge clk);
        bus.nes_pulse = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.nes_data !== 1'b1) begin
            n_fail++; $display("FAIL reset_data: got %b expected 1", bus.nes_data);
        end
        n_tests++;
        if (bit_index !== 4'd0) begin
            n_fail++; $display("FAIL reset_bit_index: got %0d expected 0", bit_index);
        end
        n_tests++;
        if (poll_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_poll: got %0d expected 0", poll_count);
        end
        n_tests++;
        if (frame_done !== 1'b0 || link_stale !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got done=%b stale=%b expected 0 0", frame_done, link_stale);
        end
    endtask

    task automatic test_idle_pulse();
        do_pulse();
        n_tests++;
        if (bus.nes_data !== 1'b1 || bit_index !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_pulse: got data=%b idx=%0d expected 1 0", bus.nes_data, bit_index);
        end
    endtask

    task automatic test_full_frame();
        int fd0;
        fd0 = fd_cnt;
        buttons_in = 8'b1001_0001;
        do_latch(12);
        n_tests++;
        if (bus.nes_data !== 1'b0 || bit_index !== 4'd0) begin
            n_fail++;
            $display("FAIL frame_load: got data=%b idx=%0d expected 0 0", bus.nes_data, bit_index);
        end
        n_tests++;
        if (poll_count !== exp_poll) begin
            n_fail++; $display("FAIL frame_poll: got %0d expected %0d", poll_count, exp_poll);
        end
        // First pulse: bit_index must move exactly one clock after the synchronized edge.
        bus.nes_pulse = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bit_index !== 4'd0) begin
            n_fail++; $display("FAIL latency_early: got idx=%0d expected 0", bit_index);
        end
        @(negedge clk);
        n_tests++;
        if (bit_index !== 4'd1 || bus.nes_data !== frame_exp[1]) begin
            n_fail++;
            $display("FAIL latency_update: got idx=%0d data=%b expected 1 %b",
                     bit_index, bus.nes_data, frame_exp[1]);
        end
        bus.nes_pulse = 1'b0;
        repeat (4) @(negedge clk);
        buttons_in = 8'b0110_1110;
        for (int i = 2; i <= 8; i++) begin
            do_pulse();
            n_tests++;
            if (i < 8) begin
                if (bus.nes_data !== frame_exp[i] || bit_index !== 4'(i)) begin
                    n_fail++;
                    $display("FAIL frame_bit%0d: got data=%b idx=%0d expected %b %0d",
                             i, bus.nes_data, bit_index, frame_exp[i], i);
                end
            end else begin
                if (bus.nes_data !== 1'b0 || bit_index !== 4'd8) begin
                    n_fail++;
                    $display("FAIL frame_end: got data=%b idx=%0d expected 0 8",
                             bus.nes_data, bit_index);
                end
            end
        end
        n_tests++;
        if (fd_cnt - fd0 !== 1) begin
            n_fail++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_overrun();
        int fd0;
        fd0 = fd_cnt;
        buttons_in = 8'b1001_0001;
        do_latch(12);
        for (int k = 1; k <= 12; k++) begin
            do_pulse();
            n_tests++;
            if (k < 8) begin
                if (bus.nes_data !== frame_exp[k] || bit_index !== 4'(k)) begin
                    n_fail++;
                    $display("FAIL overrun_bit%0d: got data=%b idx=%0d expected %b %0d",
                             k, bus.nes_data, bit_index, frame_exp[k], k);
                end
            end else if (bus.nes_data !== 1'b0 || bit_index !== 4'd8) begin
                n_fail++;
                $display("FAIL overrun_bit%0d: got data=%b idx=%0d expected 0 8",
                         k, bus.nes_data, bit_index);
            end
        end
        n_tests++;
        if (fd_cnt - fd0 !== 1) begin
            n_fail++; $display("FAIL overrun_done_count: got %0d expected 1", fd_cnt - fd0);
        end
        n_tests++;
        if (poll_count !== exp_poll) begin
            n_fail++; $display("FAIL overrun_poll: got %0d expected %0d", poll_count, exp_poll);
        end
    endtask

    task automatic test_relatch();
        int fd0;
        buttons_in = 8'b1001_0001;
        do_latch(12);
        repeat (3) do_pulse();
        fd0 = fd_cnt;
        buttons_in = 8'hFF;
        bus.nes_latch = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (bus.nes_data !== 1'b0 || bit_index !== 4'd0) begin
            n_fail++;
            $display("FAIL relatch_load: got data=%b idx=%0d expected 0 0", bus.nes_data, bit_index);
        end
        bus.nes_latch = 1'b0;
        repeat (4) @(negedge clk);
        exp_poll++;
        n_tests++;
        if (poll_count !== exp_poll) begin
            n_fail++; $display("FAIL relatch_poll: got %0d expected %0d", poll_count, exp_poll);
        end
        do_pulse();
        n_tests++;
        if (bus.nes_data !== 1'b0 || bit_index !== 4'd1) begin
            n_fail++;
            $display("FAIL relatch_shift: got data=%b idx=%0d expected 0 1", bus.nes_data, bit_index);
        end
        n_tests++;
        if (fd_cnt - fd0 !== 0) begin
            n_fail++; $display("FAIL relatch_no_done: got %0d expected 0", fd_cnt - fd0);
        end
    endtask

    task automatic test_collision();
        int fd0;
        buttons_in = 8'b1001_0001;
        do_latch(12);
        repeat (2) do_pulse();
        fd0 = fd_cnt;
        bus.nes_latch = 1'b1;
        bus.nes_pulse = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (bit_index !== 4'd0 || bus.nes_data !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_load: got idx=%0d data=%b expected 0 0", bit_index, bus.nes_data);
        end
        bus.nes_latch = 1'b0;
        bus.nes_pulse = 1'b0;
        repeat (4) @(negedge clk);
        exp_poll++;
        n_tests++;
        if (bit_index !== 4'd0) begin
            n_fail++; $display("FAIL collision_pulse_fall: got idx=%0d expected 0", bit_index);
        end
        do_pulse();
        n_tests++;
        if (bit_index !== 4'd1 || bus.nes_data !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_next: got idx=%0d data=%b expected 1 1", bit_index, bus.nes_data);
        end
        n_tests++;
        if (fd_cnt - fd0 !== 0) begin
            n_fail++; $display("FAIL collision_no_done: got %0d expected 0", fd_cnt - fd0);
        end
    endtask

    task automatic test_timeout();
        bus.nes_latch = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (link_stale !== 1'b0) begin
            n_fail++; $display("FAIL stale_clear: got %b expected 0", link_stale);
        end
        bus.nes_latch = 1'b0;
        repeat (15) @(negedge clk);
        n_tests++;
        if (link_stale !== 1'b0) begin
            n_fail++; $display("FAIL stale_early: got %b expected 0", link_stale);
        end
        @(negedge clk);
        n_tests++;
        if (link_stale !== 1'b1) begin
            n_fail++; $display("FAIL stale_set: got %b expected 1", link_stale);
        end
        repeat (10) @(negedge clk);
        exp_poll++;
        bus.nes_latch = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (link_stale !== 1'b0) begin
            n_fail++; $display("FAIL stale_relatch: got %b expected 0", link_stale);
        end
        bus.nes_latch = 1'b0;
        repeat (4) @(negedge clk);
        exp_poll++;
        n_tests++;
        if (poll_count !== exp_poll) begin
            n_fail++; $display("FAIL timeout_poll: got %0d expected %0d", poll_count, exp_poll);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] p0;
        p0 = exp_poll;
        for (int i = 0; i < 255; i++) begin
            bus.nes_latch = 1'b1;
            repeat (3) @(negedge clk);
            bus.nes_latch = 1'b0;
            repeat (4) @(negedge clk);
        end
        n_tests++;
        if (poll_count !== 8'(p0 + 8'd255)) begin
            n_fail++; $display("FAIL wrap_255: got %0d expected %0d", poll_count, 8'(p0 + 8'd255));
        end
        bus.nes_latch = 1'b1;
        repeat (3) @(negedge clk);
        bus.nes_latch = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (poll_count !== p0) begin
            n_fail++; $display("FAIL wrap_256: got %0d expected %0d", poll_count, p0);
        end
    endtask

    task automatic test_async_reset();
        int fd0;
        buttons_in = 8'b1001_0001;
        do_latch(12);
        repeat (4) do_pulse();
        n_tests++;
        if (bit_index !== 4'd4) begin
            n_fail++; $display("FAIL arst_pre: got idx=%0d expected 4", bit_index);
        end
        fd0 = fd_cnt;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (bus.nes_data !== 1'b1 || bit_index !== 4'd0 || poll_count !== 8'd0 ||
            frame_done !== 1'b0 || link_stale !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got data=%b idx=%0d poll=%0d done=%b stale=%b expected 1 0 0 0 0",
                     bus.nes_data, bit_index, poll_count, frame_done, link_stale);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_poll = 8'd0;
        do_pulse();
        n_tests++;
        if (bus.nes_data !== 1'b1 || bit_index !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_stray_pulse: got data=%b idx=%0d expected 1 0", bus.nes_data, bit_index);
        end
        n_tests++;
        if (fd_cnt - fd0 !== 0) begin
            n_fail++; $display("FAIL arst_no_done: got %0d expected 0", fd_cnt - fd0);
        end
        do_latch(6);
        n_tests++;
        if (bus.nes_data !== 1'b0 || poll_count !== exp_poll) begin
            n_fail++;
            $display("FAIL arst_new_frame: got data=%b poll=%0d expected 0 %0d",
                     bus.nes_data, poll_count, exp_poll);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        fd_cnt        = 0;
        exp_poll      = 8'd0;
        frame_exp     = 8'b0110_1110;
        rst           = 1'b0;
        buttons_in    = 8'h00;
        bus.nes_latch = 1'b0;
        bus.nes_pulse = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_idle_pulse();
        test_full_frame();
        test_overrun();
        test_relatch();
        test_collision();
        test_timeout();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on nes_latch and nes_pulse; legal values 2-3.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 24'd1_000_000: number of clk cycles without a latch before link_stale asserts.
REQ-003 clk  input  1  system clock; all flops on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 buttons_in  input  8  [0:7] = A, B, Select, Start, Up, Down, Left, Right; 1 = pressed.
REQ-006 nes_latch  input  1  latch from the external host, asynchronous to clk, active-high.
REQ-007 nes_pulse  input  1  shift clock from the external host, asynchronous to clk, active-high.
REQ-008 nes_data  output  1  serial button line, active-low (0 = pressed), registered.
REQ-009 frame_done  output  1  one-cycle pulse when the eighth bit has been shifted out.
REQ-010 bit_index  output  4  index of the bit currently on nes_data; 8 means exhausted.
REQ-011 poll_count  output  8  number of latch falling edges; wraps from 255 to 0.
REQ-012 link_stale  output  1  high when IDLE_TIMEOUT cycles have passed since the last latch rising edge.

Function
REQ-013 SHALL pass nes_latch and nes_pulse through SYNC_STAGES flops each; edge detection SHALL compare the last synchronized stage against one further registered copy.
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; the state is internal only.
REQ-015 IDLE: nes_data = 1 and bit_index = 0; a pulse edge in IDLE SHALL be ignored.
REQ-016 Any cycle with synchronized latch high SHALL force LOAD from any state; LOAD SHALL capture buttons_in into an 8-bit shift register every cycle while latch stays high.
REQ-017 In LOAD, nes_data SHALL equal ~buttons_in[0] as captured, registered one cycle after capture; bit_index = 0.
REQ-018 Latch falling edge SHALL move LOAD to SHIFT, increment poll_count, and hold the last captured value.
REQ-019 In SHIFT, each pulse rising edge SHALL advance bit_index by 1 and present ~reg[bit_index] on nes_data on the following cycle.
REQ-020 Latency from a synchronized pulse edge to nes_data update SHALL be exactly 1 clk.
REQ-021 A pulse rising edge at bit_index 7 SHALL set bit_index to 8, drive nes_data = 0 (official pad behaviour), pulse frame_done for 1 cycle, and enter DONE.
REQ-022 DONE: further pulse edges SHALL keep nes_data = 0 and bit_index = 8, with no frame_done.
REQ-023 Latch and pulse edges detected in the same cycle: latch SHALL win, the pulse edge SHALL be discarded, and the state goes to LOAD.
REQ-024 A latch rising edge in the middle of a frame (SHIFT) SHALL abort the frame without asserting frame_done.
REQ-025 Pulse falling edges SHALL have no effect.
REQ-026 buttons_in changes during SHIFT or DONE SHALL NOT affect the bits being shifted.
REQ-027 Idle counter: SHALL clear on every latch rising edge, increment otherwise, and saturate at IDLE_TIMEOUT.
REQ-028 link_stale SHALL be 1 while the idle counter equals IDLE_TIMEOUT.
REQ-029 poll_count arithmetic SHALL be 8-bit modulo, with no saturation.

Reset
REQ-030 rst low SHALL asynchronously set: state IDLE, nes_data 1, frame_done 0, bit_index 0, poll_count 0, idle counter 0, link_stale 0, all synchronizer flops 0, shift register 0.
REQ-031 Reset assertion mid-frame SHALL abort the frame with no frame_done.
REQ-032 After rst is released, the first frame SHALL be served only after a fresh latch high is observed.

Verification
REQ-033 Full frame: buttons_in = 8'b1001_0001 (A, Start, Right), latch 12 clk, then 8 pulses → nes_data sequence 0,1,1,0,1,1,1,0, then 0; frame_done pulses once; poll_count = 1.
REQ-034 Overrun: 12 pulses after the latch → bits 9-12 read 0; bit_index holds 8; exactly one frame_done.
REQ-035 Mid-frame relatch: latch after 3 pulses with buttons_in = 8'hFF → nes_data = 0 from LOAD onward; the aborted frame gives no frame_done; poll_count increments on the new falling edge.
REQ-036 Collision and stray pulses: latch and pulse asserted in the same cycle → state LOAD, bit_index 0; pulse while IDLE after reset → nes_data stays 1.
REQ-037 Timeout and wrap: with IDLE_TIMEOUT = 16, no latch for 16 cycles → link_stale = 1, cleared by the next latch; 256 latches → poll_count = 0.
REQ-038 Async reset: rst low between pulses 4 and 5 → all outputs at reset values within the same cycle, with no frame_done.
